digit_select_ctrl: RTL and testbench



---
 rtl/digit_select_ctrl_pkg.sv | 37 +++
 rtl/digit_select_ctrl_btn_debounce.sv | 49 ++++
 rtl/digit_select_ctrl.sv | 126 ++++++++++++
 tb/tb_digit_select_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/digit_select_ctrl_pkg.sv
// Shared state encodings and display symbol indices for the digit/mood selector.
// Symbol values match the indices decoded by the MAX7219 display driver.
package digit_select_ctrl_pkg;

    typedef enum logic [1:0] {
        StShowNum  = 2'd0,
        StShowMood = 2'd1,
        StBlank    = 2'd2
    } state_e;

    typedef enum logic {
        LastNum  = 1'b0,
        LastMood = 1'b1
    } last_mode_e;

    localparam logic [3:0] NUM_MAX      = 4'd9;
    localparam logic [3:0] MOOD_HAPPY   = 4'd10;
    localparam logic [3:0] MOOD_NEUTRAL = 4'd11;
    localparam logic [3:0] MOOD_SAD     = 4'd12;

    function automatic logic [3:0] num_inc(input logic [3:0] n);
        return (n >= NUM_MAX) ? 4'd0 : n + 4'd1;
    endfunction

    function automatic logic [3:0] num_dec(input logic [3:0] n);
        return (n == 4'd0) ? NUM_MAX : n - 4'd1;
    endfunction

    function automatic logic [3:0] mood_inc(input logic [3:0] m);
        return (m >= MOOD_SAD) ? MOOD_HAPPY : m + 4'd1;
    endfunction

    function automatic logic [3:0] mood_dec(input logic [3:0] m);
        return (m <= MOOD_HAPPY) ? MOOD_SAD : m - 4'd1;
    endfunction

endpackage

// File: rtl/digit_select_ctrl_btn_debounce.sv
// Two-flop synchroniser, stable-level debounce counter and press (0->1) pulse for one button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic evt_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stable_q, stable_d;
    logic            evt_q, evt_d;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        evt_d    = 1'b0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CntMax) begin
                stable_d = sync_q[1];
                evt_d    = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= 2'b00;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            evt_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            evt_q    <= evt_d;
        end
    end

    assign evt_o = evt_q;

endmodule

// File: rtl/digit_select_ctrl.sv
// Button-driven number/mood selector with inactivity blanking; feeds the MAX7219 driver's
// digit and enable inputs.
module digit_select_ctrl
    import digit_select_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 10000,
    parameter int unsigned IDLE_TIMEOUT    = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_mode,
    output logic [3:0] digit,
    output logic       enable_display,
    output logic       press_evt
);

    localparam int unsigned IdleW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_TIMEOUT - 1);

    logic up_evt, down_evt, mode_evt, any_evt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk_i(clk), .rst_i(rst), .btn_i(btn_up), .evt_o(up_evt)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk_i(clk), .rst_i(rst), .btn_i(btn_down), .evt_o(down_evt)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk_i(clk), .rst_i(rst), .btn_i(btn_mode), .evt_o(mode_evt)
    );

    assign any_evt = up_evt | down_evt | mode_evt;

    state_e          state_q, state_d;
    last_mode_e      last_q, last_d;
    logic [3:0]      num_q, num_d, mood_q, mood_d, digit_q, digit_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic            en_q, en_d, evt_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        num_d   = num_q;
        mood_d  = mood_q;
        if (any_evt) begin
            idle_d = '0;
        end else begin
            idle_d = (idle_q == '1) ? idle_q : idle_q + 1'b1;
        end

        case (state_q)
            StShowNum: begin
                if (mode_evt) begin
                    state_d = StShowMood;
                end else if (up_evt && !down_evt) begin
                    num_d = num_inc(num_q);
                end else if (down_evt && !up_evt) begin
                    num_d = num_dec(num_q);
                end else if (!any_evt && idle_q == IdleLast) begin
                    last_d  = LastNum;
                    state_d = StBlank;
                    idle_d  = '0;
                end
            end
            StShowMood: begin
                if (mode_evt) begin
                    state_d = StShowNum;
                end else if (up_evt && !down_evt) begin
                    mood_d = mood_inc(mood_q);
                end else if (down_evt && !up_evt) begin
                    mood_d = mood_dec(mood_q);
                end else if (!any_evt && idle_q == IdleLast) begin
                    last_d  = LastMood;
                    state_d = StBlank;
                    idle_d  = '0;
                end
            end
            StBlank: begin
                // The waking event is swallowed: only the mode is restored.
                if (any_evt) begin
                    state_d = (last_q == LastMood) ? StShowMood : StShowNum;
                end
            end
            default: begin
                state_d = StShowNum;
                num_d   = 4'd0;
            end
        endcase

        case (state_d)
            StShowNum:  digit_d = num_d;
            StShowMood: digit_d = mood_d;
            default:    digit_d = digit_q;
        endcase
        en_d = (state_d != StBlank);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StShowNum;
            last_q  <= LastNum;
            num_q   <= 4'd0;
            mood_q  <= MOOD_HAPPY;
            idle_q  <= '0;
            digit_q <= 4'd0;
            en_q    <= 1'b1;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            num_q   <= num_d;
            mood_q  <= mood_d;
            idle_q  <= idle_d;
            digit_q <= digit_d;
            en_q    <= en_d;
            evt_q   <= any_evt;
        end
    end

    assign digit          = digit_q;
    assign enable_display = en_q;
    assign press_evt      = evt_q;

endmodule

// File: tb/tb_digit_select_ctrl.sv
// Scoreboard bench for digit_select_ctrl with short debounce and idle parameters.
module tb_digit_select_ctrl;

    localparam int unsigned DB   = 4;
    localparam int unsigned IDLE = 100;
    localparam int unsigned LAT  = DB + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_mode = 1'b0;
    logic [3:0] digit;
    logic       enable_display;
    logic       press_evt;

    digit_select_ctrl #(.DEBOUNCE_CYCLES(DB), .IDLE_TIMEOUT(IDLE)) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_mode(btn_mode),
        .digit(digit), .enable_display(enable_display), .press_evt(press_evt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [3:0]  digit;
        logic        en;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned last_evt_cyc = 0;

    // Reference model: 0 = number, 1 = mood, 2 = blank
    int         m_state = 0, m_last = 0;
    logic [3:0] m_num = 0, m_mood = 10, m_digit = 0;

    task automatic model_evt(input logic up, input logic down, input logic mode);
        case (m_state)
            0: begin
                if (mode) m_state = 1;
                else if (up && !down) m_num = (m_num == 4'd9) ? 4'd0 : m_num + 4'd1;
                else if (down && !up) m_num = (m_num == 4'd0) ? 4'd9 : m_num - 4'd1;
            end
            1: begin
                if (mode) m_state = 0;
                else if (up && !down) m_mood = (m_mood == 4'd12) ? 4'd10 : m_mood + 4'd1;
                else if (down && !up) m_mood = (m_mood == 4'd10) ? 4'd12 : m_mood - 4'd1;
            end
            default: m_state = m_last;
        endcase
        if (m_state == 0) m_digit = m_num;
        else if (m_state == 1) m_digit = m_mood;
    endtask

    always @(negedge clk) begin
        if (!rst && press_evt) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_evt", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("evt_latency", cyc, e.cyc);
                check_eq("digit", 32'(digit), 32'(e.digit));
                check_eq("enable", 32'(enable_display), 32'(e.en));
            end
            last_evt_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) step();
    endtask

    task automatic press(input logic up, input logic down, input logic mode);
        exp_t e;
        btn_up   = up;
        btn_down = down;
        btn_mode = mode;
        model_evt(up, down, mode);
        e.digit = m_digit;
        e.en    = 1'b1;
        e.cyc   = cyc + LAT;
        sb_q.push_back(e);
        repeat (10) step();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_mode = 1'b0;
        repeat (10) step();
    endtask

    int unsigned u;

    initial begin
        repeat (3) step();
        rst = 1'b0;
        check_eq("rst_digit", 32'(digit), 32'd0);
        check_eq("rst_enable", 32'(enable_display), 32'd1);
        check_eq("rst_evt", 32'(press_evt), 32'd0);

        for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 1'b0);

        // Bounce: 2-cycle pulses, then a clean hold
        for (int i = 0; i < 5; i++) begin
            btn_down = 1'b1; step(); step();
            btn_down = 1'b0; step(); step();
        end
        press(1'b0, 1'b1, 1'b0);

        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b1, 1'b0);

        // Idle from the up+down activity: blank exactly IDLE cycles after that update
        u = last_evt_cyc;
        wait_cyc(u + IDLE - 1);
        check_eq("pre_timeout_en", 32'(enable_display), 32'd1);
        wait_cyc(u + IDLE);
        check_eq("timeout_en", 32'(enable_display), 32'd0);
        check_eq("timeout_digit", 32'(digit), 32'(m_digit));
        m_last = m_state; m_state = 2;

        press(1'b1, 1'b0, 1'b0);

        // Event whose update lands on the would-be timeout edge
        u = last_evt_cyc;
        wait_cyc(u + IDLE - LAT);
        press(1'b1, 1'b0, 1'b0);
        check_eq("no_blank_en", 32'(enable_display), 32'd1);

        press(1'b0, 1'b0, 1'b1);
        u = last_evt_cyc;
        wait_cyc(u + IDLE);
        check_eq("mood_blank_en", 32'(enable_display), 32'd0);
        check_eq("mood_blank_digit", 32'(digit), 32'(m_digit));
        m_last = m_state; m_state = 2;

        // Reset while blanked with a press mid-debounce
        btn_up = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        btn_up = 1'b0;
        step();
        check_eq("midrst_digit", 32'(digit), 32'd0);
        check_eq("midrst_enable", 32'(enable_display), 32'd1);
        check_eq("midrst_evt", 32'(press_evt), 32'd0);
        rst = 1'b0;
        m_state = 0; m_last = 0; m_num = 0; m_mood = 10; m_digit = 0;
        repeat (20) step();

        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        check_eq("sb_drain", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
